sdm_mod2_tx: RTL and testbench

Second-order digital sigma-delta modulator: the transmit end of the 1-bit modulator link. Accepts unsigned WIDTH-bit words over a valid/ready handshake and produces a 1-bit density stream (`mdata1`) with its bit clock (`mclkout`) and a once-per-frame word strobe (`word_clk`). The output is shaped for the team's sinc3 decimator, which samples `mdata1` on the falling edge of the modulator clock. Used for loopback self-test and for driving the filter path from a digital source.

---
 rtl/sdm_mod2_tx_if.sv | 24 ++
 rtl/sdm_mod2_tx.sv | 168 ++++++++++++++++
 tb/tb_sdm_mod2_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdm_mod2_tx_if.sv
// Sample-input handshake for the second-order sigma-delta transmitter.
// The source (master) drives a word and its valid flag; the modulator
// (slave) returns ready while its one-entry input buffer is empty.
interface sdm_mod2_tx_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/sdm_mod2_tx.sv
// Second-order 1-bit sigma-delta modulator, transmit side of the modulator link.
// Takes unsigned WIDTH-bit words (density = din / 2^WIDTH), one per frame of
// dec_rate bits, and emits mdata1 with its bit clock mclkout and a word_clk frame
// strobe. mdata1 only changes with mclkout rising, so a receiver sampling on the
// falling edge sees CLK_DIV/2 clocks of setup and hold.
module sdm_mod2_tx #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned dec_rate = 256,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ACC_W    = WIDTH + 4
) (
  input  logic         mclkin,
  input  logic         rst_n,
  sdm_mod2_tx_if.slave din_bus,
  output logic         mclkout,
  output logic         mdata1,
  output logic         word_clk,
  output logic         underrun
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(dec_rate);
  // Two guard bits so sums never wrap before they are clamped.
  localparam int unsigned EW = ACC_W + 2;

  typedef logic signed [EW-1:0]    ext_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam longint SatHiL = (longint'(1) << (WIDTH + 2)) - 1;
  localparam longint SatLoL = -(longint'(1) << (WIDTH + 2));
  localparam longint FbL    = longint'(1) << WIDTH;

  localparam ext_t SatHi = EW'(SatHiL);
  localparam ext_t SatLo = EW'(SatLoL);
  localparam ext_t FbVal = EW'(FbL);

  localparam logic [WIDTH-1:0] MidScale = {1'b1, {(WIDTH - 1){1'b0}}};

  // Bit-clock divider and bit-in-frame index.
  logic [DW-1:0] d_q;
  logic [BW-1:0] b_q;

  // One-entry input buffer and the word driving the current frame.
  logic             buf_full_q;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] x_hold_q;

  // Integrators.
  acc_t i1_q, i2_q;
  acc_t i1_d, i2_d;

  // Registered outputs.
  logic mclkout_q, mdata1_q, word_clk_q, underrun_q;

  logic             tick;
  logic             fall;
  logic             boundary;
  logic             xfer;
  logic             load;
  logic             bit_now;
  logic [WIDTH-1:0] x_sel;
  ext_t             x_ext;
  ext_t             fb_ext;
  ext_t             i1_sum;
  ext_t             i2_sum;

  function automatic ext_t sext(input acc_t v);
    return {{(EW - ACC_W){v[ACC_W-1]}}, v};
  endfunction

  function automatic acc_t sat(input ext_t v);
    if (v > SatHi) begin
      return ACC_W'(SatHi);
    end else if (v < SatLo) begin
      return ACC_W'(SatLo);
    end else begin
      return ACC_W'(v);
    end
  endfunction

  assign tick     = (d_q == DW'(CLK_DIV - 1));
  assign fall     = (d_q == DW'(CLK_DIV / 2 - 1));
  assign boundary = tick && (b_q == '0);
  assign xfer     = din_bus.din_valid && !buf_full_q;
  // A full buffer at a boundary is consumed; the same edge can never also accept
  // a word, because ready is low while the buffer is full.
  assign load     = boundary && buf_full_q;

  assign din_bus.din_ready = !buf_full_q;

  assign mclkout  = mclkout_q;
  assign mdata1   = mdata1_q;
  assign word_clk = word_clk_q;
  assign underrun = underrun_q;

  // Modulator next state: quantise on the sign of i2, then feed back full scale.
  always_comb begin
    x_sel   = load ? buf_q : x_hold_q;
    x_ext   = ext_t'({{(EW - WIDTH){1'b0}}, x_sel});
    bit_now = !i2_q[ACC_W-1];
    fb_ext  = bit_now ? FbVal : '0;
    i1_sum  = sext(i1_q) + x_ext - fb_ext;
    i1_d    = sat(i1_sum);
    i2_sum  = sext(i2_q) + sext(i1_d) - fb_ext;
    i2_d    = sat(i2_sum);
  end

  // Bit-clock divider and frame bit counter (dec_rate is a power of two, so b wraps).
  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      b_q <= '0;
    end else begin
      d_q <= tick ? '0 : d_q + DW'(1);
      if (tick) begin
        b_q <= b_q + BW'(1);
      end
    end
  end

  // Input buffer and per-frame word hand-over; an empty buffer at a boundary keeps
  // the previous word and flags an underrun.
  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      x_hold_q   <= MidScale;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= boundary && !buf_full_q;
      if (load) begin
        x_hold_q   <= buf_q;
        buf_full_q <= 1'b0;
      end
      if (xfer) begin
        buf_q      <= din_bus.din;
        buf_full_q <= 1'b1;
      end
    end
  end

  // Integrators advance once per output bit.
  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
    end else if (tick) begin
      i1_q <= i1_d;
      i2_q <= i2_d;
    end
  end

  // Bit clock, data and frame strobe all launch on the tick edge.
  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      mclkout_q  <= 1'b0;
      mdata1_q   <= 1'b0;
      word_clk_q <= 1'b0;
    end else if (tick) begin
      mclkout_q  <= 1'b1;
      mdata1_q   <= bit_now;
      word_clk_q <= boundary;
    end else if (fall) begin
      mclkout_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdm_mod2_tx.sv
// Bench for sdm_mod2_tx: a cycle-level behavioural model (edge count since reset,
// queue-like one-word buffer, integer integrators) checked every clock, plus
// hand-computed expectations for start-up, densities, boundary and reset cases.
module tb_sdm_mod2_tx;

  localparam int W    = 16;
  localparam int DEC  = 256;
  localparam int CDIV = 4;
  localparam int FRM  = DEC * CDIV;

  logic mclkin = 1'b0;
  logic rst_n  = 1'b1;
  logic mclkout, mdata1, word_clk, underrun;

  sdm_mod2_tx_if #(.WIDTH(W)) bus ();

  sdm_mod2_tx #(
    .WIDTH   (W),
    .dec_rate(DEC),
    .CLK_DIV (CDIV),
    .ACC_W   (W + 4)
  ) dut (
    .mclkin  (mclkin),
    .rst_n   (rst_n),
    .din_bus (bus.slave),
    .mclkout (mclkout),
    .mdata1  (mdata1),
    .word_clk(word_clk),
    .underrun(underrun)
  );

  always #5 mclkin = ~mclkin;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint         m_n;      // rising edges since reset release
  longint         m_k;      // index of the bit produced by the latest tick
  longint         m_i1, m_i2;
  logic [W-1:0]   m_buf, m_xhold;
  bit             m_full, m_under, m_mdata, m_tick;

  localparam longint SAT_HI = (longint'(1) << (W + 2)) - 1;
  localparam longint SAT_LO = -(longint'(1) << (W + 2));

  function automatic longint sat(input longint v);
    if (v > SAT_HI) return SAT_HI;
    if (v < SAT_LO) return SAT_LO;
    return v;
  endfunction

  function automatic bit exp_mclk();
    return (m_n >= CDIV) && ((m_n % CDIV) < (CDIV / 2));
  endfunction

  function automatic bit exp_wclk();
    return (m_n >= CDIV) && (((m_n / CDIV - 1) % DEC) == 0);
  endfunction

  task automatic model_reset();
    m_n = 0; m_k = 0; m_i1 = 0; m_i2 = 0;
    m_full = 0; m_buf = '0; m_xhold = 16'h8000;
    m_under = 0; m_mdata = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d);
    bit     bnd, tx, bt;
    longint x, fb;
    m_n++;
    m_tick  = (m_n % CDIV) == 0;
    bnd     = m_tick && (((m_n / CDIV - 1) % DEC) == 0);
    tx      = v && !m_full;
    m_under = bnd && !m_full;
    x       = longint'(m_xhold);
    if (bnd && m_full) begin
      m_xhold = m_buf;
      x       = longint'(m_buf);
      m_full  = 0;
    end
    if (tx) begin
      m_buf  = d;
      m_full = 1;
    end
    if (m_tick) begin
      m_k     = m_n / CDIV - 1;
      bt      = (m_i2 >= 0);
      fb      = bt ? (longint'(1) << W) : 0;
      m_i1    = sat(m_i1 + x - fb);
      m_i2    = sat(m_i2 + m_i1 - fb);
      m_mdata = bt;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge mclkin or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(bus.din_valid, bus.din);
    end
  end

  // ---------------- stimulus driver ----------------
  logic [W-1:0] q[$];
  bit           rand_gap = 0;
  bit           ready_seen = 0;

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    forever begin
      @(negedge mclkin);
      if (!rst_n) begin
        bus.din_valid = 1'b0;
        ready_seen    = 1'b0;
      end else begin
        if (bus.din_valid && ready_seen && q.size() > 0) void'(q.pop_front());
        ready_seen = bus.din_ready;
        if (q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
          bus.din_valid = 1'b1;
          bus.din       = q[0];
        end else begin
          bus.din_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en  = 0;
  bit sat_bad = 0;
  int ones[16];
  bit bits_cur[300];
  bit ref_bits[300];

  initial begin
    wait (chk_en);
    forever begin
      @(posedge mclkin);
      #1;
      check("mclkout", mclkout, exp_mclk());
      check("word_clk", word_clk, rst_n ? exp_wclk() : 1'b0);
      check("mdata1", mdata1, m_mdata);
      check("underrun", underrun, m_under);
      check("din_ready", bus.din_ready, !m_full);
      if (longint'(dut.i1_q) > SAT_HI || longint'(dut.i1_q) < SAT_LO ||
          longint'(dut.i2_q) > SAT_HI || longint'(dut.i2_q) < SAT_LO) sat_bad = 1;
      if (rst_n && m_tick) begin
        if (m_k / DEC < 16) ones[m_k / DEC] += int'(mdata1);
        if (m_k < 300) bits_cur[m_k] = mdata1;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic clear_counts();
    for (int i = 0; i < 16; i++) ones[i] = 0;
    for (int i = 0; i < 300; i++) bits_cur[i] = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge mclkin);
    #2;
  endtask

  // Leaves the DUT released 2 time units after a rising edge: the next edge is edge 1.
  task automatic do_reset();
    @(posedge mclkin);
    #2;
    rst_n = 1'b0;
    q.delete();
    rand_gap = 0;
    clear_counts();
    run_cycles(3);
    rst_n = 1'b1;
  endtask

  // Start-up pattern for edges 1..8 after release with no input.
  bit tab_mclk[8]  = '{0, 0, 0, 1, 1, 0, 0, 1};
  bit tab_wclk[8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
  bit tab_mdata[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  bit tab_under[8] = '{0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    int mism;
    #1 rst_n = 1'b0;
    #1 chk_en = 1;

    // 1: reset, no input
    do_reset();
    for (int e = 0; e < 8; e++) begin
      run_cycles(1);
      check($sformatf("start_mclk_e%0d", e + 1), mclkout, tab_mclk[e]);
      check($sformatf("start_wclk_e%0d", e + 1), word_clk, tab_wclk[e]);
      check($sformatf("start_mdata_e%0d", e + 1), mdata1, tab_mdata[e]);
      check($sformatf("start_under_e%0d", e + 1), underrun, tab_under[e]);
    end
    run_cycles(3 * FRM);
    check("idle_frame1_under_wclk", word_clk, 1'b0);
    for (int i = 0; i < 300; i++) ref_bits[i] = bits_cur[i];

    // 2: midscale every frame
    do_reset();
    repeat (8) q.push_back(16'h8000);
    run_cycles(5 * FRM + 8);
    for (int f = 1; f <= 4; f++) check_range($sformatf("mid_ones_f%0d", f), ones[f], 126, 130);

    // 3: zero input
    do_reset();
    repeat (8) q.push_back(16'h0000);
    run_cycles(5 * FRM + 8);
    for (int f = 2; f <= 4; f++) check($sformatf("zero_ones_f%0d", f), ones[f], 0);

    // 4: full-scale input
    do_reset();
    repeat (8) q.push_back(16'hFFFF);
    run_cycles(5 * FRM + 8);
    for (int f = 2; f <= 4; f++) check_range($sformatf("full_ones_f%0d", f), ones[f], 254, 256);

    // 5: back-to-back words with valid held high
    do_reset();
    q.push_back(16'h4000);
    q.push_back(16'hC000);
    run_cycles(1);
    check("b2b_a_taken_ready", bus.din_ready, 0);
    run_cycles(2);
    check("b2b_b_held_ready", bus.din_ready, 0);
    run_cycles(1);
    check("b2b_boundary_ready", bus.din_ready, 1);
    run_cycles(1);
    check("b2b_b_taken_ready", bus.din_ready, 0);
    run_cycles(3 * FRM);
    check_range("b2b_ones_a", ones[0], 62, 66);
    check_range("b2b_ones_b", ones[1], 190, 194);

    // 6: word arrives exactly on the first boundary edge
    do_reset();
    run_cycles(3);
    q.push_back(16'h4000);
    run_cycles(1);
    check("edge_underrun", underrun, 1);
    check("edge_ready", bus.din_ready, 0);
    run_cycles(3 * FRM);
    check_range("edge_ones_hold", ones[0], 126, 130);
    check_range("edge_ones_word", ones[1], 62, 66);

    // 7: reset mid-frame (frame 1, bit 100) with a word still buffered
    do_reset();
    repeat (4) q.push_back(16'h2000);
    run_cycles(FRM + 4 * 101 + 1);
    check("midrst_pre_mclk", mclkout, 1);
    check("midrst_pre_ready", bus.din_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_mclk", mclkout, 0);
    check("midrst_mdata", mdata1, 0);
    check("midrst_wclk", word_clk, 0);
    check("midrst_under", underrun, 0);
    check("midrst_ready", bus.din_ready, 1);
    q.delete();
    clear_counts();
    run_cycles(3);
    rst_n = 1'b1;
    run_cycles(1300);
    mism = 0;
    for (int i = 0; i < 300; i++) if (bits_cur[i] != ref_bits[i]) mism++;
    check("midrst_stream_mismatches", mism, 0);

    // 8: random words, random valid gaps, occasional skipped frames
    do_reset();
    rand_gap = 1;
    repeat (7) begin
      run_cycles($urandom_range(200, 1200));
      if ($urandom_range(0, 2) != 0) q.push_back(W'($urandom_range(0, 65535)));
    end
    run_cycles(2 * FRM);

    check("sat_range", sat_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
